// File: rtl/mkio_bc_scheduler_if.sv
// rtl/mkio_bc_scheduler_if.sv - channel encoder/decoder and data RAM bus of the MKIO BC scheduler
interface mkio_bc_scheduler_if;
    logic [15:0] tx_data;
    logic        tx_cd;
    logic        tx_ready;
    logic        tx_busy;
    logic        rx_done;
    logic [15:0] rx_data;
    logic        p_error;
    logic [6:0]  dat_addr;
    logic [15:0] dat_in;

    modport master (
        output tx_data, tx_cd, tx_ready, dat_addr,
        input  tx_busy, rx_done, rx_data, p_error, dat_in
    );

    modport slave (
        input  tx_data, tx_cd, tx_ready, dat_addr,
        output tx_busy, rx_done, rx_data, p_error, dat_in
    );
endinterface

// File: rtl/mkio_bc_scheduler.sv
// rtl/mkio_bc_scheduler.sv - MKIO bus-controller frame scheduler for BC->RT receive messages
module mkio_bc_scheduler #(
    parameter int NUM_CMD   = 4,
    parameter int TIMEOUT   = 200,
    parameter int MAX_RETRY = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [1:0]          cfg_addr,
    input  logic [15:0]         cfg_data,
    input  logic [NUM_CMD-1:0]  cfg_en,
    input  logic                frame_start,
    mkio_bc_scheduler_if.master bus,
    output logic                busy,
    output logic                frame_done,
    output logic [NUM_CMD-1:0]  msg_ok,
    output logic [NUM_CMD-1:0]  msg_err,
    output logic [7:0]          retry_cnt
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_SELECT, S_SEND_CMD, S_TX_WAIT, S_DATA_ADDR,
        S_DATA_SEND, S_RESP, S_FAIL, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   tbl_q [4];
    logic [15:0]   tbl_d [4];
    logic [3:0]    en_q, en_d, ok_q, ok_d, err_q, err_d;
    logic [2:0]    slot_q, slot_d;
    logic [4:0]    widx_q, widx_d;
    logic [15:0]   cmd_q, cmd_d;
    logic          ret_data_q, ret_data_d;
    logic          seen_busy_q, seen_busy_d;
    logic [7:0]    attempt_q, attempt_d;
    logic [7:0]    retry_q, retry_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [6:0]    dat_addr_q, dat_addr_d;
    logic [15:0]   tx_data;
    logic          tx_cd, tx_ready;
    logic [1:0]    slot_idx;
    logic [4:0]    word_last;
    logic          rx_hit;
    logic          unused_rx;

    assign slot_idx  = slot_q[1:0];
    // count field 0 wraps to 31, so a 32-word message ends at widx 31
    assign word_last = cmd_q[4:0] - 5'd1;
    // a word from another RT with good parity is not ours and is ignored
    assign rx_hit    = bus.rx_done && (bus.p_error || (bus.rx_data[15:11] == cmd_q[15:11]));
    assign unused_rx = ^bus.rx_data[9:0];

    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign frame_done   = (state_q == S_DONE);
    assign msg_ok       = ok_q[NUM_CMD-1:0];
    assign msg_err      = err_q[NUM_CMD-1:0];
    assign retry_cnt    = retry_q;
    assign bus.dat_addr = dat_addr_q;
    assign bus.tx_data  = tx_data;
    assign bus.tx_cd    = tx_cd;
    assign bus.tx_ready = tx_ready;

    // next-state, table write port and encoder load strobe
    always_comb begin
        state_d     = state_q;
        tbl_d       = tbl_q;
        en_d        = en_q;
        ok_d        = ok_q;
        err_d       = err_q;
        slot_d      = slot_q;
        widx_d      = widx_q;
        cmd_d       = cmd_q;
        ret_data_d  = ret_data_q;
        seen_busy_d = seen_busy_q;
        attempt_d   = attempt_q;
        retry_d     = retry_q;
        tmo_d       = tmo_q;
        dat_addr_d  = dat_addr_q;
        tx_ready    = 1'b0;
        tx_data     = '0;
        tx_cd       = 1'b0;
        if (cfg_we) tbl_d[cfg_addr] = cfg_data;
        case (state_q)
            S_IDLE: if (frame_start) begin
                ok_d    = '0;
                err_d   = '0;
                retry_d = '0;
                slot_d  = '0;
                en_d    = '0;
                en_d[NUM_CMD-1:0] = cfg_en;
                state_d = S_SELECT;
            end
            S_SELECT: begin
                if (int'(slot_q) >= NUM_CMD) begin
                    state_d = S_DONE;
                end else if (!en_q[slot_idx] || tbl_q[slot_idx][10]) begin
                    slot_d = slot_q + 3'd1;
                end else begin
                    attempt_d = '0;
                    cmd_d     = tbl_q[slot_idx];
                    state_d   = S_SEND_CMD;
                end
            end
            S_SEND_CMD: if (!bus.tx_busy) begin
                tx_ready    = 1'b1;
                tx_data     = cmd_q;
                tx_cd       = 1'b1;
                widx_d      = '0;
                ret_data_d  = 1'b1;
                seen_busy_d = 1'b0;
                state_d     = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                if (!seen_busy_q) begin
                    seen_busy_d = bus.tx_busy;
                end else if (!bus.tx_busy) begin
                    if (ret_data_q) begin
                        dat_addr_d = {slot_idx, widx_q};
                        state_d    = S_DATA_ADDR;
                    end else begin
                        tmo_d   = '0;
                        state_d = S_RESP;
                    end
                end
            end
            S_DATA_ADDR: state_d = S_DATA_SEND;
            S_DATA_SEND: if (!bus.tx_busy) begin
                tx_ready    = 1'b1;
                tx_data     = bus.dat_in;
                seen_busy_d = 1'b0;
                state_d     = S_TX_WAIT;
                if (widx_q == word_last) begin
                    ret_data_d = 1'b0;
                end else begin
                    widx_d     = widx_q + 5'd1;
                    ret_data_d = 1'b1;
                end
            end
            S_RESP: begin
                if (rx_hit) begin
                    if (bus.p_error || bus.rx_data[10]) begin
                        state_d = S_FAIL;
                    end else begin
                        ok_d[slot_idx] = 1'b1;
                        slot_d         = slot_q + 3'd1;
                        state_d        = S_SELECT;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_FAIL;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_FAIL: begin
                if (int'(attempt_q) < MAX_RETRY) begin
                    attempt_d = attempt_q + 8'd1;
                    if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
                    cmd_d     = tbl_q[slot_idx];
                    state_d   = S_SEND_CMD;
                end else begin
                    err_d[slot_idx] = 1'b1;
                    slot_d          = slot_q + 3'd1;
                    state_d         = S_SELECT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < 4; i++) tbl_q[i] <= '0;
            en_q        <= '0;
            ok_q        <= '0;
            err_q       <= '0;
            slot_q      <= '0;
            widx_q      <= '0;
            cmd_q       <= '0;
            ret_data_q  <= 1'b0;
            seen_busy_q <= 1'b0;
            attempt_q   <= '0;
            retry_q     <= '0;
            tmo_q       <= '0;
            dat_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            tbl_q       <= tbl_d;
            en_q        <= en_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
            slot_q      <= slot_d;
            widx_q      <= widx_d;
            cmd_q       <= cmd_d;
            ret_data_q  <= ret_data_d;
            seen_busy_q <= seen_busy_d;
            attempt_q   <= attempt_d;
            retry_q     <= retry_d;
            tmo_q       <= tmo_d;
            dat_addr_q  <= dat_addr_d;
        end
    end
endmodule

// File: tb/tb_mkio_bc_scheduler.sv
// tb/tb_mkio_bc_scheduler.sv - randomized self-checking bench for mkio_bc_scheduler
module tb_mkio_bc_scheduler;
    localparam int NUM_CMD = 4, TIMEOUT = 200, MAX_RETRY = 2;

    logic        clk = 1'b0, reset = 1'b0;
    logic        cfg_we = 1'b0, frame_start = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [15:0] cfg_data = '0;
    logic [3:0]  cfg_en = '0;
    logic        busy, frame_done;
    logic [3:0]  msg_ok, msg_err;
    logic [7:0]  retry_cnt;

    mkio_bc_scheduler_if ifc();

    mkio_bc_scheduler #(.NUM_CMD(NUM_CMD), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_en(cfg_en), .frame_start(frame_start), .bus(ifc), .busy(busy),
        .frame_done(frame_done), .msg_ok(msg_ok), .msg_err(msg_err), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int nw; logic [15:0] w0; logic [15:0] w1; bit pe0; bit pe1; int d0; int d1;
    } plan_t;

    plan_t       plans[$];
    plan_t       cur;
    logic [15:0] ram [128];
    logic [15:0] tbl [4];
    logic [16:0] cap[$], exp_q[$];
    int          gaps[$];
    int          viol, cyc, fall_cyc;
    logic [3:0]  exp_ok, exp_err;
    int          exp_retry;
    bit          done_seen, busy_seen;
    int          seq_bad;
    int          n_checks = 0, n_fail = 0;

    // data RAM with one clock of read latency
    initial begin
        ifc.dat_in = '0;
        forever @(posedge clk) ifc.dat_in <= ram[ifc.dat_addr];
    end

    // encoder and RT responder, stepped on the falling edge
    initial begin
        int enc_cnt, rt_rem, r_i, r_dly;
        bit load_pend, resp_pend, r_act, ready_now;
        enc_cnt = 0; rt_rem = 0; r_i = 0; r_dly = 0;
        load_pend = 0; resp_pend = 0; r_act = 0;
        cyc = 0; fall_cyc = 0; viol = 0;
        ifc.tx_busy = 1'b0; ifc.rx_done = 1'b0; ifc.rx_data = '0; ifc.p_error = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            ifc.rx_done = 1'b0;
            ifc.p_error = 1'b0;
            if (!reset) begin
                enc_cnt = 0; load_pend = 0; resp_pend = 0; r_act = 0; rt_rem = 0;
                ifc.tx_busy = 1'b0;
            end else begin
                ready_now = ifc.tx_ready;
                if (ready_now && ifc.tx_busy) viol++;
                if (enc_cnt > 0) begin
                    enc_cnt--;
                    if (enc_cnt == 0) begin
                        ifc.tx_busy = 1'b0;
                        fall_cyc = cyc;
                        if (resp_pend && rt_rem == 0 && !r_act) begin
                            r_act = 1; r_i = 0; r_dly = cur.d0;
                        end
                    end
                end else if (load_pend) begin
                    ifc.tx_busy = 1'b1;
                    enc_cnt = $urandom_range(4, 2);
                    load_pend = 0;
                end
                if (ready_now) begin
                    cap.push_back({ifc.tx_cd, ifc.tx_data});
                    load_pend = 1;
                    if (ifc.tx_cd) begin
                        if (resp_pend) gaps.push_back(cyc - fall_cyc);
                        rt_rem = (ifc.tx_data[4:0] == 5'd0) ? 32 : int'(ifc.tx_data[4:0]);
                        if (plans.size() > 0) cur = plans.pop_front();
                        else cur = '{0, 16'h0, 16'h0, 0, 0, 1, 1};
                        resp_pend = 1; r_act = 0;
                    end else if (rt_rem > 0) begin
                        rt_rem--;
                    end
                end
                if (r_act) begin
                    if (r_i >= cur.nw) begin
                        r_act = 0;
                    end else if (r_dly > 0) begin
                        r_dly--;
                    end else begin
                        ifc.rx_done = 1'b1;
                        ifc.rx_data = (r_i == 0) ? cur.w0 : cur.w1;
                        ifc.p_error = (r_i == 0) ? cur.pe0 : cur.pe1;
                        r_i++;
                        r_dly = cur.d1;
                        if (r_i >= cur.nw) begin r_act = 0; resp_pend = 0; end
                    end
                end
            end
        end
    end

    function automatic plan_t mkp(int nw, logic [15:0] w0, bit pe0, logic [15:0] w1, bit pe1);
        plan_t p;
        p.nw = nw; p.w0 = w0; p.pe0 = pe0; p.w1 = w1; p.pe1 = pe1;
        p.d0 = $urandom_range(20, 1); p.d1 = $urandom_range(20, 1);
        return p;
    endfunction

    function automatic logic [15:0] good_word(logic [4:0] rt);
        return {rt, 1'b0, 10'($urandom)};
    endfunction

    function automatic plan_t rnd_plan(logic [4:0] rt);
        logic [4:0] other;
        other = rt ^ 5'($urandom_range(31, 1));
        case ($urandom_range(4, 0))
            0: return mkp(0, 16'h0, 0, 16'h0, 0);
            1: return mkp(1, good_word(rt), 0, 16'h0, 0);
            2: return mkp(1, good_word(rt), 1, 16'h0, 0);
            3: return mkp(2, good_word(other), 0, good_word(rt), 0);
            default: return mkp(1, {rt, 1'b1, 10'($urandom)}, 0, 16'h0, 0);
        endcase
    endfunction

    task automatic write_cfg(int s, logic [15:0] w);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 2'(s); cfg_data = w;
        tbl[s] = w;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // expected frame from the message rules: words sent, per-slot outcome, retries
    task automatic model(input logic [3:0] en);
        plan_t pl[$];
        int pi, n;
        bit good;
        pl = plans; pi = 0;
        exp_q.delete(); exp_ok = '0; exp_err = '0; exp_retry = 0;
        for (int s = 0; s < NUM_CMD; s++) begin
            if (!en[s] || tbl[s][10]) continue;
            n = (tbl[s][4:0] == 5'd0) ? 32 : int'(tbl[s][4:0]);
            for (int a = 0; a <= MAX_RETRY; a++) begin
                plan_t p;
                exp_q.push_back({1'b1, tbl[s]});
                for (int i = 0; i < n; i++) exp_q.push_back({1'b0, ram[s*32 + i]});
                if (pi < pl.size()) p = pl[pi]; else p = '{0, 16'h0, 16'h0, 0, 0, 1, 1};
                pi++;
                good = 0;
                for (int k = 0; k < p.nw; k++) begin
                    logic [15:0] w; bit pe;
                    w = (k == 0) ? p.w0 : p.w1; pe = (k == 0) ? p.pe0 : p.pe1;
                    if (pe) break;
                    if (w[15:11] != tbl[s][15:11]) continue;
                    good = !w[10];
                    break;
                end
                if (good) begin exp_ok[s] = 1'b1; break; end
                if (a < MAX_RETRY) exp_retry = (exp_retry < 255) ? exp_retry + 1 : 255;
                else exp_err[s] = 1'b1;
            end
        end
    endtask

    task automatic do_frame(input logic [3:0] en, input bit double_start);
        int m;
        model(en);
        cap.delete(); gaps.delete(); viol = 0;
        @(negedge clk);
        cfg_en = en; frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        busy_seen = busy;
        if (double_start) begin
            repeat (3) @(negedge clk);
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
        end
        done_seen = 0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (frame_done) begin done_seen = 1; break; end
        end
        @(negedge clk);
        seq_bad = -1;
        m = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
        for (int i = 0; i < m; i++) if (cap[i] !== exp_q[i]) begin seq_bad = i; break; end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, frame_done, msg_ok, msg_err, retry_cnt, ifc.tx_ready, ifc.tx_cd, ifc.tx_data, ifc.dat_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b ok=%b err=%b retry=%0d rdy=%b addr=%0d, all must be 0",
                     busy, frame_done, msg_ok, msg_err, retry_cnt, ifc.tx_ready, ifc.dat_addr);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        plans.delete();
        plans.push_back(mkp(1, 16'h0800, 0, 16'h0, 0));
        write_cfg(0, {5'd1, 1'b0, 5'd2, 5'd3});
        do_frame(4'b0001, 1);
        n_checks++; if (busy_seen !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy_seen); end
        n_checks++; if (done_seen !== 1'b1) begin n_fail++; $display("FAIL basic_frame_done: not seen within bound"); end
        n_checks++; if (cap.size() !== 4) begin n_fail++; $display("FAIL basic_words: got %0d expected 4", cap.size()); end
        n_checks++; if (seq_bad !== -1) begin n_fail++; $display("FAIL basic_seq: first bad word %0d got %h expected %h", seq_bad, cap[seq_bad], exp_q[seq_bad]); end
        n_checks++; if (msg_ok !== 4'b0001 || msg_err !== 4'b0000) begin n_fail++; $display("FAIL basic_flags: ok=%b err=%b expected 0001/0000", msg_ok, msg_err); end
        n_checks++; if (retry_cnt !== 8'd0) begin n_fail++; $display("FAIL basic_retry: got %0d expected 0", retry_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_cnt0();
        logic [4:0] rt;
        rt = 5'($urandom);
        plans.delete();
        plans.push_back(mkp(1, good_word(rt), 0, 16'h0, 0));
        write_cfg(1, {rt, 1'b0, 5'($urandom), 5'd0});
        do_frame(4'b0010, 0);
        n_checks++; if (cap.size() !== 33) begin n_fail++; $display("FAIL cnt0_words: got %0d expected 33", cap.size()); end
        n_checks++; if (seq_bad !== -1) begin n_fail++; $display("FAIL cnt0_seq: first bad word %0d got %h expected %h", seq_bad, cap[seq_bad], exp_q[seq_bad]); end
        n_checks++; if (msg_ok !== 4'b0010 || msg_err !== 4'b0000) begin n_fail++; $display("FAIL cnt0_flags: ok=%b err=%b expected 0010/0000", msg_ok, msg_err); end
    endtask

    task automatic test_timeout();
        plans.delete();
        for (int i = 0; i < 3; i++) plans.push_back(mkp(0, 16'h0, 0, 16'h0, 0));
        write_cfg(0, {5'd1, 1'b0, 5'd2, 5'd3});
        do_frame(4'b0001, 0);
        n_checks++; if (cap.size() !== 12 || seq_bad !== -1) begin n_fail++; $display("FAIL timeout_seq: words %0d expected 12, first bad %0d", cap.size(), seq_bad); end
        n_checks++; if (msg_err !== 4'b0001 || msg_ok !== 4'b0000) begin n_fail++; $display("FAIL timeout_flags: ok=%b err=%b expected 0000/0001", msg_ok, msg_err); end
        n_checks++; if (retry_cnt !== 8'd2) begin n_fail++; $display("FAIL timeout_retry: got %0d expected 2", retry_cnt); end
        n_checks++; if (gaps.size() !== 2) begin n_fail++; $display("FAIL timeout_attempts: got %0d retried commands expected 2", gaps.size()); end
        foreach (gaps[i]) begin
            n_checks++;
            if (gaps[i] < TIMEOUT || gaps[i] > TIMEOUT + 3) begin
                n_fail++; $display("FAIL timeout_gap%0d: got %0d clks expected %0d..%0d", i, gaps[i], TIMEOUT, TIMEOUT + 3);
            end
        end
    endtask

    task automatic test_parity_retry();
        plans.delete();
        plans.push_back(mkp(1, good_word(5'd1), 1, 16'h0, 0));
        plans.push_back(mkp(1, good_word(5'd1), 0, 16'h0, 0));
        do_frame(4'b0001, 0);
        n_checks++; if (seq_bad !== -1 || cap.size() !== exp_q.size()) begin n_fail++; $display("FAIL parity_seq: words %0d expected %0d, first bad %0d", cap.size(), exp_q.size(), seq_bad); end
        n_checks++; if (msg_ok !== 4'b0001 || msg_err !== 4'b0000) begin n_fail++; $display("FAIL parity_flags: ok=%b err=%b expected 0001/0000", msg_ok, msg_err); end
        n_checks++; if (retry_cnt !== 8'd1) begin n_fail++; $display("FAIL parity_retry: got %0d expected 1", retry_cnt); end
    endtask

    task automatic test_wrong_addr();
        plans.delete();
        plans.push_back(mkp(2, good_word(5'd3), 0, good_word(5'd1), 0));
        do_frame(4'b0001, 0);
        n_checks++; if (msg_ok !== 4'b0001 || msg_err !== 4'b0000) begin n_fail++; $display("FAIL wrong_addr_flags: ok=%b err=%b expected 0001/0000", msg_ok, msg_err); end
        n_checks++; if (retry_cnt !== 8'd0 || cap.size() !== 4) begin n_fail++; $display("FAIL wrong_addr_retry: retry %0d words %0d expected 0/4", retry_cnt, cap.size()); end
    endtask

    task automatic test_skip_tr();
        plans.delete();
        plans.push_back(mkp(1, good_word(5'd9), 0, 16'h0, 0));
        plans.push_back(mkp(1, good_word(5'd4), 0, 16'h0, 0));
        write_cfg(0, {5'd2, 1'b0, 5'd1, 5'd2});
        write_cfg(1, {5'd9, 1'b0, 5'd7, 5'd5});
        write_cfg(2, {5'd3, 1'b0, 5'd1, 5'd1});
        write_cfg(3, {5'd4, 1'b1, 5'd1, 5'd2});
        do_frame(4'b1010, 0);
        n_checks++; if (seq_bad !== -1 || cap.size() !== 6) begin n_fail++; $display("FAIL skip_seq: words %0d expected 6, first bad %0d", cap.size(), seq_bad); end
        n_checks++; if (msg_ok !== 4'b0010 || msg_err !== 4'b0000) begin n_fail++; $display("FAIL skip_flags: ok=%b err=%b expected 0010/0000", msg_ok, msg_err); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            logic [3:0] en;
            plans.delete();
            for (int s = 0; s < 4; s++)
                write_cfg(s, {5'($urandom), ($urandom_range(3, 0) == 0), 5'($urandom), 5'($urandom_range(8, 0))});
            for (int k = 0; k < 12; k++) plans.push_back(rnd_plan(tbl[k / 3][15:11]));
            en = 4'($urandom);
            do_frame(en, 0);
            n_checks++; if (done_seen !== 1'b1) begin n_fail++; $display("FAIL rand%0d_frame_done: not seen within bound", f); end
            n_checks++; if (seq_bad !== -1 || cap.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand%0d_seq: words %0d expected %0d, first bad %0d", f, cap.size(), exp_q.size(), seq_bad); end
            n_checks++; if (msg_ok !== exp_ok || msg_err !== exp_err) begin n_fail++; $display("FAIL rand%0d_flags: ok=%b err=%b expected %b/%b", f, msg_ok, msg_err, exp_ok, exp_err); end
            n_checks++; if (int'(retry_cnt) !== exp_retry) begin n_fail++; $display("FAIL rand%0d_retry: got %0d expected %0d", f, retry_cnt, exp_retry); end
            n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL rand%0d_ready_busy: tx_ready while busy %0d times, expected 0", f, viol); end
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        bit reached;
        plans.delete();
        write_cfg(0, {5'd6, 1'b0, 5'd3, 5'd0});
        cap.delete();
        @(negedge clk);
        cfg_en = 4'b0001; frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        reached = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (cap.size() >= 5) begin reached = 1; break; end
        end
        n_checks++; if (!reached) begin n_fail++; $display("FAIL reset_mid_progress: only %0d words before bound", cap.size()); end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({busy, frame_done, msg_ok, msg_err, retry_cnt, ifc.tx_ready, ifc.tx_cd, ifc.tx_data, ifc.dat_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: busy=%b ok=%b err=%b retry=%0d rdy=%b addr=%0d, all must be 0",
                     busy, msg_ok, msg_err, retry_cnt, ifc.tx_ready, ifc.dat_addr);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (frame_done || busy) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL reset_mid_abort: busy/frame_done seen %0d cycles after reset, expected 0", pulses); end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ram[i] = 16'($urandom);
        for (int i = 0; i < 4; i++) tbl[i] = '0;
        test_reset();
        test_basic();
        test_cnt0();
        test_timeout();
        test_parity_retry();
        test_wrong_addr();
        test_skip_tr();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mkio_bc_scheduler.md
Name: mkio_bc_scheduler

Overview:
- Bus-controller message scheduler for the MKIO (GOST 26765.52 / MIL-STD-1553) channel.
- On each frame start it walks a small command table of BC→RT receive messages.
- For each slot it sends the command word, then N data words fetched from a shared data RAM, then waits for the RT response word with timeout and retry.
- Per-slot results are reported. It sits between the host configuration logic, the channel TX encoder/RX decoder and the data RAM.

Parameters:
- NUM_CMD, 4: command table slots (1..4; slot index is 2 bits).
- TIMEOUT, 200: clk cycles to wait for a response word after the last data word's transmission ends.
- MAX_RETRY, 2: retries per slot after the first attempt fails.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- cfg_we  in  1  command table write strobe
- cfg_addr  in  2  slot index for cfg write
- cfg_data  in  16  command word: [15:11] RT address, [10] T/R (must be 0), [9:5] subaddress, [4:0] word count (0 = 32)
- cfg_en  in  NUM_CMD  slot enable mask; bit i enables slot i
- frame_start  in  1  one-cycle pulse; starts a frame
- tx_data  out  16  word to encoder
- tx_cd  out  1  1 = command sync, 0 = data sync
- tx_ready  out  1  one-cycle load strobe to encoder
- tx_busy  in  1  encoder transmitting
- rx_done  in  1  one-cycle pulse; rx_data valid
- rx_data  in  16  received word
- p_error  in  1  parity error on current rx word, valid with rx_done
- dat_addr  out  7  data RAM read address {slot[1:0], word[4:0]}
- dat_in  in  16  data RAM output; valid 1 clk after dat_addr changes
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse at end of frame
- msg_ok  out  NUM_CMD  slot i completed with a good response
- msg_err  out  NUM_CMD  slot i failed after all retries
- retry_cnt  out  8  total retries in the current frame, saturates at 255

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; command table cleared to 16'h0000.
- Command table:
  - cfg_we writes cfg_data to slot cfg_addr in any state.
  - A write to the slot currently active takes effect on the next attempt.
  - cfg_en is sampled at frame_start.
- States:
  - IDLE: busy=0. frame_start → clear msg_ok, msg_err, retry_cnt; slot=0; go to SELECT; busy=1.
  - SELECT: if slot ≥ NUM_CMD → DONE. Else if enable bit clear or T/R=1 → leave slot flags 0, slot++. Else → SEND_CMD with attempt=0.
  - SEND_CMD: wait tx_busy=0. Drive tx_data=command word, tx_cd=1, and pulse tx_ready for 1 clk. Go to TX_WAIT; return target = DATA.
  - TX_WAIT: wait for tx_busy=1, then tx_busy=0, then continue to the return target.
  - DATA: set dat_addr={slot, widx}; wait 1 clk (RAM latency). Drive tx_data=dat_in, tx_cd=0, pulse tx_ready. Go to TX_WAIT.
    - Return target is DATA with widx+1 while widx < N-1; otherwise RESP.
    - N = count field, with 0 meaning 32.
  - RESP: clear the timeout counter on entry and count each clk.
    - rx_done with rx_data[15:11]==RT address, p_error=0 and rx_data[10]=0 → set msg_ok[slot]; slot++; go to SELECT.
    - rx_done with an address mismatch is ignored; keep waiting.
    - rx_done with p_error=1 or rx_data[10]=1 → FAIL.
    - Counter reaches TIMEOUT → FAIL.
  - FAIL:
    - If attempt < MAX_RETRY → attempt++, retry_cnt++ (saturating), go to SEND_CMD.
    - Else → set msg_err[slot]; slot++; go to SELECT.
  - DONE: pulse frame_done for 1 clk; busy=0; go to IDLE.
- frame_start while busy=1 is ignored.
- rx_done outside RESP is ignored.
- If rx_done and timeout expiry occur in the same clk, rx_done wins.
- tx_ready is never asserted while tx_busy=1.
- widx is 5 bits; a count of 0 sends 32 words, covering widx 0..31 with no wrap.
- Reset during a frame aborts immediately; no frame_done is produced.

Test Plan:
- Slot0 = {RT 5'd1, R, SA 5'd2, cnt 3}, cfg_en=4'b0001, RT answers 16'h0800 → 1 command word + 3 data words from addr 0..2, msg_ok=0001, frame_done, retry_cnt=0.
- Slot1 count=0, cfg_en=4'b0010 → 32 data words from addr 32..63, then response → msg_ok=0010.
- No RT response, MAX_RETRY=2 → 3 command attempts, each failure after 200 clks; msg_err=0001; retry_cnt=2.
- First response has p_error=1, second is good → msg_ok set, retry_cnt=1.
- Response from wrong RT address 5'd3 followed by the correct 5'd1 → wrong word ignored, msg_ok set.
- cfg_en=4'b1010 with slot3 T/R=1 → only slot1 runs; slot3 flags stay 0. Reset asserted mid-data phase → all outputs 0 immediately.
